// File: rtl/zet_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the 16-bit memory bus.
// Master 0 (PF) is the read-only prefetch unit that streams with cyc held high.
// Master 1 (DAT) is the data/IO master. DAT has priority, but PF is guaranteed
// PF_MIN acks per grant before DAT may take the bus, and only on an ack cycle.
module zet_wb_arbiter #(
  parameter int unsigned PF_MIN = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0: prefetch (read-only)
  input  logic [19:1] m0_adr_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  // master 1: data / IO
  input  logic [19:1] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  // slave
  output logic [19:1] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  // current grant, one-hot: [0]=PF, [1]=DAT
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_PF  = 2'd1,
    GNT_DAT = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] pf_cnt_reg, pf_cnt_next;

  // The ack being counted now is included when testing the quota, so DAT can
  // take over on exactly the PF_MIN-th ack rather than one transfer later.
  logic [4:0] pf_cnt_inc;
  logic       pf_quota_met;
  logic [1:0] ack_vec;

  assign pf_cnt_inc   = {1'b0, pf_cnt_reg} + 5'd1;
  assign pf_quota_met = (pf_cnt_inc >= 5'(PF_MIN));

  // State and PF transfer counter registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg  <= IDLE;
      pf_cnt_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      pf_cnt_reg <= pf_cnt_next;
    end
  end

  // Next-state arbitration: DAT wins ties, PF preemption only on an ack
  always_comb begin
    state_next  = state_reg;
    pf_cnt_next = pf_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (m1_cyc_i) begin
          state_next = GNT_DAT;
        end else if (m0_cyc_i) begin
          state_next  = GNT_PF;
          pf_cnt_next = 4'd0;
        end
      end
      GNT_DAT: begin
        // DAT holds the bus until it drops cyc; hand straight to PF if waiting
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_next  = GNT_PF;
            pf_cnt_next = 4'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GNT_PF: begin
        if (!m0_cyc_i) begin
          state_next = m1_cyc_i ? GNT_DAT : IDLE;
        end else if (s_ack_i && m1_cyc_i && pf_quota_met) begin
          state_next = GNT_DAT;
        end else if (s_ack_i && (pf_cnt_reg != 4'hF)) begin
          pf_cnt_next = pf_cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slave-side mux: route the granted master, quiet bus when idle
  always_comb begin
    s_adr_o = '0;
    s_dat_o = m1_dat_i;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    gnt_o   = 2'b00;
    case (state_reg)
      GNT_PF: begin
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        gnt_o   = 2'b01;
      end
      GNT_DAT: begin
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        gnt_o   = 2'b10;
      end
      default: ;
    endcase
  end

  // Ack steering: only the granted master ever sees the slave ack
  for (genvar gi = 0; gi < 2; gi++) begin : g_ack
    assign ack_vec[gi] = s_ack_i & gnt_o[gi];
  end

  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];

  // Read data is shared and unregistered; the ack tells each master when it is valid
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
